// File: rtl/tcu_drl_acc_sched.sv
// Accumulation sequencer for the FEDP datapath: splits one dot-product request
// into (N-1)-wide product steps and folds each step's sum into a running result.
// Optional perf counters are enabled with `define TCU_ACC_SCHED_PERF_EN.
module tcu_drl_acc_sched #(
  parameter int N    = 5,
  parameter int W    = 26,
  parameter int WA   = 30,
  parameter int LAT  = 1,
  parameter int LENW = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_req_id,
  input  logic [LENW-1:0]      in_len,
  input  logic [W-1:0]         in_c,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [(N-1)*W-1:0]   prod_sigs,
  input  logic [N-2:0]         prod_sticky,
  output logic                 acc_valid,
  output logic [31:0]          acc_req_id,
  output logic [N-2:0]         acc_lane_mask,
  output logic [N*W-1:0]       acc_sigs,
  output logic [N-1:0]         acc_sticky,
  input  logic [WA-1:0]        acc_sig_out,
  input  logic                 acc_sticky_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_req_id,
  output logic [WA-1:0]        out_sig,
  output logic                 out_sticky
`ifdef TCU_ACC_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_busy,
  output logic [31:0]          perf_stall
`endif
);

  localparam int PL = N - 1;
  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [LENW:0] PL_V  = (LENW+1)'(PL);
  localparam logic [LENW:0] ONE_V = (LENW+1)'(1);
  localparam logic [CW-1:0] LAT_V = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_id;
  logic [W-1:0]    r_c;
  logic            r_len0;
  logic            r_first;
  logic [LENW:0]   r_steps_left;
  logic [LENW:0]   r_rem;
  logic [CW-1:0]   r_wait_cnt;
  logic [WA-1:0]   r_sum;
  logic            r_sticky;

  logic [LENW:0]   w_len_ext;
  logic [LENW:0]   w_steps_raw;
  logic [LENW:0]   w_steps;
  logic [LENW:0]   w_rem;
  logic            w_accept;
  logic            w_issue;
  logic            w_capture;
  logic            w_last;
  logic [PL-1:0]   w_mask;

  // Step count and last-step remainder for the request being offered.
  always_comb begin
    w_len_ext   = {1'b0, in_len};
    w_steps_raw = (w_len_ext + PL_V - ONE_V) / PL_V;
    if (w_steps_raw == (LENW+1)'(0)) begin
      w_steps = ONE_V;
    end else begin
      w_steps = w_steps_raw;
    end
    w_rem = w_len_ext - ((w_steps - ONE_V) * PL_V);
  end

  // Handshake and step-event decode.
  always_comb begin
    w_accept = (r_state == S_IDLE) && in_valid;
    w_issue  = (r_state == S_ISSUE) && (r_len0 || prod_valid);
    w_last   = (r_steps_left == ONE_V);
    if (LAT == 0) begin
      w_capture = w_issue;
    end else begin
      w_capture = (r_state == S_WAIT) && (r_wait_cnt == CNT_ONE);
    end
  end

  // Lane mask: full except on the last step, which keeps only the low r_rem lanes.
  always_comb begin
    w_mask = {PL{1'b1}};
    for (int i = 0; i < PL; i++) begin
      if (w_last) begin
        w_mask[i] = ((LENW+1)'(i) < r_rem);
      end else begin
        w_mask[i] = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state; with LAT=0 the capture lands in ISSUE and WAIT is skipped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_issue && w_capture) begin
          w_next = w_last ? S_DONE : S_ISSUE;
        end else if (w_issue) begin
          w_next = S_WAIT;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (w_capture) begin
          w_next = w_last ? S_DONE : S_ISSUE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs; datapath lanes are zeroed outside ISSUE.
  always_comb begin
    in_ready   = (r_state == S_IDLE);
    prod_ready = (r_state == S_ISSUE) && !r_len0;
    acc_valid  = w_issue;
    acc_req_id = r_id;
    out_valid  = (r_state == S_DONE);
    out_req_id = r_id;
    out_sig    = r_sum;
    out_sticky = r_sticky;
    if (r_state == S_ISSUE) begin
      acc_lane_mask = w_mask;
      acc_sticky    = {1'b0, prod_sticky};
      if (r_first) begin
        acc_sigs = {r_c, prod_sigs};
      end else begin
        acc_sigs = {{W{1'b0}}, prod_sigs};
      end
    end else begin
      acc_lane_mask = {PL{1'b0}};
      acc_sticky    = {N{1'b0}};
      acc_sigs      = {(N*W){1'b0}};
    end
  end

  // Request context, step bookkeeping and the wrapping running sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id         <= 32'd0;
      r_c          <= {W{1'b0}};
      r_len0       <= 1'b0;
      r_first      <= 1'b0;
      r_steps_left <= {(LENW+1){1'b0}};
      r_rem        <= {(LENW+1){1'b0}};
      r_wait_cnt   <= {CW{1'b0}};
      r_sum        <= {WA{1'b0}};
      r_sticky     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id         <= in_req_id;
        r_c          <= in_c;
        r_len0       <= (in_len == {LENW{1'b0}});
        r_first      <= 1'b1;
        r_steps_left <= w_steps;
        r_rem        <= w_rem;
        r_sum        <= {WA{1'b0}};
        r_sticky     <= 1'b0;
      end
      if (w_issue) begin
        r_first    <= 1'b0;
        r_wait_cnt <= LAT_V;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != {CW{1'b0}})) begin
        r_wait_cnt <= r_wait_cnt - CNT_ONE;
      end
      if (w_capture) begin
        r_sum        <= r_sum + acc_sig_out;
        r_sticky     <= r_sticky | acc_sticky_out;
        r_steps_left <= r_steps_left - ONE_V;
      end
    end
  end

`ifdef TCU_ACC_SCHED_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  // Free-running busy and stall counters; both wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_busy  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (r_state != S_IDLE) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
      if (((r_state == S_ISSUE) && !prod_valid) || ((r_state == S_DONE) && !out_ready)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_busy  = r_perf_busy;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_tcu_drl_acc_sched.sv
// Self-checking bench for tcu_drl_acc_sched (N=5, W=26, WA=30, LAT=1) with a
// one-cycle datapath model, table-driven requests and issue/result scoreboards.
module tb_tcu_drl_acc_sched;

  localparam int N    = 5;
  localparam int W    = 26;
  localparam int WA   = 30;
  localparam int LAT  = 1;
  localparam int LENW = 8;
  localparam int NV   = 11;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_req_id;
  logic [LENW-1:0]     in_len;
  logic [W-1:0]        in_c;
  logic                prod_valid;
  logic                prod_ready;
  logic [(N-1)*W-1:0]  prod_sigs;
  logic [N-2:0]        prod_sticky;
  logic                acc_valid;
  logic [31:0]         acc_req_id;
  logic [N-2:0]        acc_lane_mask;
  logic [N*W-1:0]      acc_sigs;
  logic [N-1:0]        acc_sticky;
  logic [WA-1:0]       acc_sig_out;
  logic                acc_sticky_out;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_req_id;
  logic [WA-1:0]       out_sig;
  logic                out_sticky;

  int n_checks = 0;
  int errors   = 0;
  int cyc      = 0;
  int last_issue = 0;

  typedef struct {
    int             len;
    logic [W-1:0]   c;
    logic [W-1:0]   pv;
    int             stk_lane;
    int             stk_grp;
    int             dly;
    int             steps;
    logic [N-2:0]   last_mask;
    logic [WA-1:0]  sig;
    logic           sticky;
  } vec_t;

  typedef struct {
    logic [31:0]   id;
    logic [N-2:0]  mask;
    logic [W-1:0]  clane;
    logic          chk_gap;
  } issue_t;

  typedef struct {
    logic [31:0]   id;
    logic [WA-1:0] sig;
    logic          sticky;
  } res_t;

  vec_t   tv [NV];
  issue_t iq [$];
  res_t   sb [$];

  tcu_drl_acc_sched #(.N(N), .W(W), .WA(WA), .LAT(LAT), .LENW(LENW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_req_id      (in_req_id),
    .in_len         (in_len),
    .in_c           (in_c),
    .prod_valid     (prod_valid),
    .prod_ready     (prod_ready),
    .prod_sigs      (prod_sigs),
    .prod_sticky    (prod_sticky),
    .acc_valid      (acc_valid),
    .acc_req_id     (acc_req_id),
    .acc_lane_mask  (acc_lane_mask),
    .acc_sigs       (acc_sigs),
    .acc_sticky     (acc_sticky),
    .acc_sig_out    (acc_sig_out),
    .acc_sticky_out (acc_sticky_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_req_id     (out_req_id),
    .out_sig        (out_sig),
    .out_sticky     (out_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Datapath model: signed sum of enabled product lanes plus the C lane, one cycle later.
  function automatic logic [WA-1:0] dp_sum(input logic [N*W-1:0] s, input logic [N-2:0] m);
    logic [WA-1:0] a;
    a = WA'($signed(s[N*W-1 -: W]));
    for (int i = 0; i < N-1; i++) begin
      if (m[i]) a = a + WA'($signed(s[i*W +: W]));
    end
    return a;
  endfunction

  logic [WA-1:0] dp_sig;
  logic          dp_st;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_sig <= '0;
      dp_st  <= 1'b0;
    end else if (acc_valid) begin
      dp_sig <= dp_sum(acc_sigs, acc_lane_mask);
      dp_st  <= (|(acc_sticky[N-2:0] & acc_lane_mask)) | acc_sticky[N-1];
    end
  end
  assign acc_sig_out    = dp_sig;
  assign acc_sticky_out = dp_st;

  // Issue monitor: every acc_valid pulse must match the next expected step.
  always @(negedge clk) begin
    if (reset_n && acc_valid) begin
      if (iq.size() == 0) begin
        fail_now("unexpected_issue");
      end else begin
        issue_t e;
        e = iq.pop_front();
        chk("issue_mask", 64'(acc_lane_mask), 64'(e.mask));
        chk("issue_clane", 64'(acc_sigs[N*W-1 -: W]), 64'(e.clane));
        chk("issue_id", 64'(acc_req_id), 64'(e.id));
        if (e.chk_gap) chk("issue_gap", 64'(cyc - last_issue), 64'(LAT + 1));
        last_issue = cyc;
      end
    end
  end

  task automatic run_req(input int k);
    vec_t          t;
    logic [31:0]   id;
    int            ngroups, g, ov, n, pr_hi, acc_n;
    logic          hs_p, done, stable_ok, inr_ok, acc_ok;
    logic [WA-1:0] ref_sig;
    logic          ref_st;
    res_t          r;
    t  = tv[k];
    id = 32'hA000_0000 + 32'(k);
    ngroups = (t.len + N - 2) / (N - 1);
    sb.push_back('{id, t.sig, t.sticky});
    for (int s = 0; s < t.steps; s++) begin
      iq.push_back('{id, (s == t.steps - 1) ? t.last_mask : {(N-1){1'b1}},
                     (s == 0) ? t.c : {W{1'b0}}, (s > 0)});
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_req_id = id; in_len = LENW'(t.len); in_c = t.c;
    prod_valid = 1'b0; out_ready = (t.dly == 0);
    acc_ok = 1'b0; acc_n = 0;
    while (!acc_ok && acc_n < 50) begin
      @(negedge clk); acc_ok = in_ready;
      @(posedge clk); #1; acc_n++;
    end
    in_valid = 1'b0;
    if (!acc_ok) begin
      fail_now("accept_timeout");
      return;
    end
    g = 0; ov = 0; n = 0; pr_hi = 0; done = 1'b0; stable_ok = 1'b1; inr_ok = 1'b1;
    ref_sig = '0; ref_st = 1'b0;
    while (!done && n < 400) begin
      prod_valid  = (g < ngroups) || (t.len == 0);
      prod_sigs   = {(N-1){t.pv}};
      prod_sticky = (t.stk_lane >= 0 && g == t.stk_grp) ? ((N-1)'(1) << t.stk_lane) : '0;
      out_ready   = (ov >= t.dly);
      @(negedge clk);
      hs_p = prod_valid && prod_ready;
      if (prod_ready) pr_hi++;
      if (out_valid) begin
        if (ov == 0) begin
          ref_sig = out_sig; ref_st = out_sticky;
        end else if (out_sig !== ref_sig || out_sticky !== ref_st || out_req_id !== id) begin
          stable_ok = 1'b0;
        end
        if (in_ready) inr_ok = 1'b0;
        ov++;
        if (out_ready) begin
          r = sb.pop_front();
          chk("out_id", 64'(out_req_id), 64'(r.id));
          chk("out_sig", 64'(out_sig), 64'(r.sig));
          chk("out_sticky", 64'(out_sticky), 64'(r.sticky));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (hs_p) g++;
      n++;
    end
    prod_valid = 1'b0; out_ready = 1'b0;
    if (!done) begin
      fail_now("result_timeout");
    end else begin
      chk("out_stable", 64'(stable_ok), 64'd1);
      chk("in_ready_low_in_done", 64'(inr_ok), 64'd1);
      chk("out_valid_cycles", 64'(ov), 64'(t.dly + 1));
      chk("groups_consumed", 64'(g), 64'(ngroups));
      if (t.len == 0) chk("len0_prod_ready", 64'(pr_hi), 64'd0);
      @(negedge clk);
      chk("in_ready_after", 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    tv[0]  = '{8,  26'd5,         26'd1,         -1, 0, 0, 2,  4'hF, 30'd13,         1'b0};
    tv[1]  = '{6,  26'd0,         26'd1,         -1, 0, 0, 2,  4'h3, 30'd6,          1'b0};
    tv[2]  = '{0,  26'h3FFFFFD,   26'd1,         -1, 0, 0, 1,  4'h0, 30'h3FFFFFFD,   1'b0};
    tv[3]  = '{4,  26'd0,         26'd1,          2, 0, 5, 1,  4'hF, 30'd4,          1'b1};
    tv[4]  = '{16, 26'h1FFFFFF,   26'h1FFFFFF,   -1, 0, 0, 4,  4'hF, 30'h21FFFFEF,   1'b0};
    tv[5]  = '{40, 26'h1FFFFFF,   26'h1FFFFFF,   -1, 0, 0, 10, 4'hF, 30'h11FFFFD7,   1'b0};
    tv[6]  = '{5,  26'd7,         26'h3FFFFFE,   -1, 0, 0, 2,  4'h1, 30'h3FFFFFFD,   1'b0};
    tv[7]  = '{3,  26'h3FFFFFF,   26'd2,         -1, 0, 2, 1,  4'h7, 30'd5,          1'b0};
    tv[8]  = '{6,  26'd0,         26'd1,          3, 1, 0, 2,  4'h3, 30'd6,          1'b0};
    tv[9]  = '{9,  26'd0,         26'd100,        0, 2, 1, 3,  4'h1, 30'd900,        1'b1};
    tv[10] = '{4,  26'd3,         26'd5,         -1, 0, 0, 1,  4'hF, 30'd23,         1'b0};

    reset_n = 1'b0; in_valid = 1'b0; in_req_id = '0; in_len = '0; in_c = '0;
    prod_valid = 1'b0; prod_sigs = '0; prod_sticky = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_prod_ready", 64'(prod_ready), 64'd0);
    chk("rst_acc_valid", 64'(acc_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sig", 64'(out_sig), 64'd0);
    chk("rst_out_sticky", 64'(out_sticky), 64'd0);
    reset_n = 1'b1;

    for (int k = 0; k < NV - 1; k++) run_req(k);

    // Reset in the WAIT of a 3-step request, then a clean request.
    @(posedge clk); #1;
    in_valid = 1'b1; in_req_id = 32'hB000_0001; in_len = 8'd12; in_c = 26'd9;
    iq.push_back('{32'hB000_0001, 4'hF, 26'd9, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0; prod_valid = 1'b1; prod_sigs = {(N-1){26'd1}}; prod_sticky = 4'hF;
    @(negedge clk);
    chk("mid_prod_ready", 64'(prod_ready), 64'd1);
    @(posedge clk); #1;
    prod_valid = 1'b0; prod_sticky = '0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_prod_ready", 64'(prod_ready), 64'd0);
    chk("mid_rst_acc_valid", 64'(acc_valid), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_sig", 64'(out_sig), 64'd0);
    chk("mid_rst_out_sticky", 64'(out_sticky), 64'd0);
    chk("mid_rst_out_id", 64'(out_req_id), 64'd0);
    chk("mid_rst_acc_id", 64'(acc_req_id), 64'd0);
    chk("mid_rst_acc_sigs", 64'(acc_sigs[63:0]), 64'd0);
    chk("mid_rst_pending_issues", 64'(iq.size()), 64'd0);
    iq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_req(NV - 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tcu_drl_acc_sched.md
Name: tcu_drl_acc_sched

Overview:
- Sequencer for the FEDP accumulation datapath.
- Takes one dot-product request of arbitrary length and streams its products in groups of N-1 into the combinational accumulator. Masks the trailing partial group, injects the C term on the first step only, and folds each step's sum into a WA-wide running register.
- Sits between the TCU product stage and the normalizer; emits one tagged result per request.

Parameters:
N, 5, accumulator lanes (N-1 product lanes + 1 C lane)
W, 26, product/C significand width (signed)
WA, 30, accumulator and result width (signed)
LAT, 1, cycles from acc_valid to acc_sig_out valid (0 = same cycle)
LENW, 8, width of request length field

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_req_id  in  32  request tag
in_len  in  LENW  number of products in the request
in_c  in  W  signed C term
prod_valid  in  1  product group valid
prod_ready  out  1  product group consumed
prod_sigs  in  (N-1)*W  product significands, lane 0 lowest
prod_sticky  in  N-1  per-lane sticky
acc_valid  out  1  step issued to datapath
acc_req_id  out  32  tag driven to datapath
acc_lane_mask  out  N-1  lane enables
acc_sigs  out  N*W  lanes 0..N-2 = prod_sigs; lane N-1 = C or 0
acc_sticky  out  N  sticky to datapath
acc_sig_out  in  WA  datapath sum, valid LAT cycles after acc_valid
acc_sticky_out  in  1  datapath sticky, aligned with acc_sig_out
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_req_id  out  32  result tag
out_sig  out  WA  accumulated signed sum
out_sticky  out  1  OR of all step stickies

Behaviour:
- Reset (async, reset_n=0) clears everything: state=IDLE, in_ready=1, prod_ready=0, acc_valid=0, out_valid=0. Running sum, sticky, counters and outputs are all 0. Reset mid-request drops the request silently.
- Step math:
  - S = max(1, ceil(in_len/(N-1))).
  - Last-step remainder R = in_len - (S-1)*(N-1), in range 1..N-1. For in_len=0, R=0.
  - Mask is all-ones for non-last steps and the low R bits on the last step.
- IDLE: in_ready=1. On accept, latch id, c and step count; clear sum and sticky; go to ISSUE.
- ISSUE: prod_ready=1, except when in_len=0 the step issues without consuming a product.
  - On prod_valid (or immediately when in_len=0), drive for one cycle: acc_valid=1, acc_sigs, mask, sticky.
  - Lane N-1 carries in_c on step 0 and 0 on later steps. acc_sticky[N-1]=0.
  - Then go to WAIT with wait counter = LAT.
- WAIT: prod_ready=0. Decrement the counter. When it reaches 0 (same cycle as issue if LAT=0, so WAIT is skipped):
  - sum <= sum + acc_sig_out, using a WA-bit two's-complement add that wraps; there is no saturation.
  - sticky |= acc_sticky_out.
  - If the step counter is exhausted go to DONE, else back to ISSUE.
- DONE: out_valid=1; out_sig, out_sticky and out_req_id stay stable until out_ready. On the handshake go to IDLE; in_ready rises the next cycle.
- Steps are strictly serialised: at most one step is in flight, and the issue-to-issue gap is LAT+1 cycles (LAT=0: 1).
- prod_valid in IDLE/WAIT/DONE is ignored and not consumed.
- Extra products beyond in_len are the producer's error and are not consumed.
- acc_req_id equals the latched id for the whole request. Masked lanes still carry raw prod_sigs; the datapath applies the mask.

Optional Feature:
TCU_ACC_SCHED_PERF_EN:
- Defined: adds outputs perf_busy[31:0], counting cycles not in IDLE, and perf_stall[31:0], counting ISSUE cycles with prod_valid=0 plus DONE cycles with out_ready=0.
- Both counters wrap, reset to 0, and are free-running across requests.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan (N=5, W=26, WA=30, LAT=1):
1. len=8, c=5, products all 1 in two groups, acc model = signed sum of masked lanes.
   -> 2 issues with masks 1111/1111; C lane 5 then 0; out_sig=13; issue gap 2 cycles.
2. len=6, c=0, products 1.
   -> masks 1111 then 0011; upper lanes of step 2 excluded; out_sig=6.
3. len=0, c=-3.
   -> one issue, mask 0000, prod_ready=0 throughout; out_sig=-3 (0x3FFFFFFD).
4. len=4, product lane 2 sticky=1; out_ready held low 5 cycles.
   -> out_sticky=1; out_valid and data stable 5 cycles; in_ready=0 until the cycle after the handshake.
5. reset_n low during WAIT of a 3-step request, then a new len=4 request.
   -> all outputs 0 immediately; new request result is correct with no residue.
6. Sums overflowing WA (four lanes of 0x1FFFFFF over 4 steps).
   -> out_sig wraps modulo 2^30 and matches the reference model.
